demux_rr_dispatcher: RTL and testbench
======================================

// Module: demux_rr_dispatcher
// PURPOSE
//  Round-robin dispatcher that sits directly upstream of the 1x4 demux stage.
//  - Accepts words from a single valid/ready source and buffers one word.
//  - Drives sel/data for the demux and a one-hot per-channel valid.
//  - Holds each word until the addressed channel accepts it, so no word is lost.
// PARAMETERS
//  DATA_W     8   width of the data word
//  SKIP_BUSY  1   1: choose the first ready channel from ptr; 0: strict order ptr, ptr+1, ...
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  in_data      in   DATA_W  source word
//  in_valid     in   1       source word valid
//  in_ready     out  1       dispatcher can take a word this cycle
//  ch_ready     in   4       per-channel ready from the consumers
//  sel          out  2       channel select to the demux (registered)
//  out_data     out  DATA_W  held word to the demux (registered)
//  out_valid    out  4       one-hot valid, out_valid[sel], or 4'b0000
//  ptr          out  2       next round-robin start channel
//  xfer_count   out  8       completed transfers, wraps 255->0
// BEHAVIOUR
//  Clock and reset
//  - One clock domain (clk). Reset is asynchronous, active low (rst_n).
//  - Reset values: state=IDLE, sel=0, out_data=0, out_valid=0, ptr=0, xfer_count=0.
//  - in_ready=0 while rst_n=0.
//  States
//  - IDLE: no word held; out_valid=0.
//  - HOLD: one word held; out_valid = 4'b0001<<sel.
//  Handshakes
//  - in_ready = rst_n & (state==IDLE | ch_ready[sel]), combinational.
//  - Accept = in_valid & in_ready. Transfer = state==HOLD & ch_ready[sel].
//  - Word accepted at edge N is presented from edge N onward, i.e. 1-cycle latency.
//  Channel choice at accept (start = ptr, or sel+1 mod 4 if a transfer occurs the same cycle)
//  - SKIP_BUSY=1: first channel c in start, start+1, ... (mod 4) with ch_ready[c]=1.
//    If none is ready, c=start.
//  - SKIP_BUSY=0: c=start.
//  On accept
//  - out_data<=in_data, sel<=c, state<=HOLD.
//  On transfer
//  - ptr<=sel+1 (wraps 3->0), xfer_count<=xfer_count+1 (wraps 255->0).
//  - state<=IDLE unless an accept happens in the same cycle.
//  Simultaneous transfer + accept
//  - Both take effect in one edge, giving back-to-back words with no bubble.
//  - The new channel is searched from sel+1 in that cycle.
//  Hold stability
//  - While in HOLD with no transfer: sel, out_data and out_valid stay constant.
//  - in_data/in_valid changes are ignored.
//  Other rules
//  - in_valid without in_ready: no state change; the source must hold its word.
//  - ch_ready on unselected channels never causes a transfer.
//  - out_valid is never multi-hot.
//  - Reset mid-HOLD: the word is discarded, all outputs return to reset values
//    asynchronously, and ptr restarts at 0.
// TESTING
//  T1 reset: rst_n=0 mid-HOLD -> out_valid=0, sel=0, ptr=0, xfer_count=0, in_ready=0 immediately.
//  T2 strict rr (SKIP_BUSY=0):
//     stimulus: ch_ready=4'hF, in_valid=1 for 6 cycles, words 0x11..0x16.
//     response: out_valid 1,2,4,8,1,2 on consecutive cycles; xfer_count=6; no bubbles.
//  T3 backpressure:
//     stimulus: one word 0xA5, ch_ready=0 for 5 cycles, then ch_ready[0]=1.
//     response: in_ready=0, out_data=0xA5, out_valid=0001 held stable; transfer on the
//     ch_ready cycle; ptr=1.
//  T4 skip (SKIP_BUSY=1): ptr=1, ch_ready=4'b1001, word 0x3C -> sel=3, out_valid=1000, ptr->0.
//  T5 wrap: 256 transfers -> xfer_count returns to 0; ptr sequence wraps 3->0 correctly.
//  T6 simultaneous: HOLD sel=2 with ch_ready[2]=1 and in_valid=1 (0x77)
//     -> same edge: transfer counted, sel=3, out_data=0x77.

Source files
------------

// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher feeding a 1x4 demux. It buffers one word from a
// valid/ready source and presents it on a registered sel/data/one-hot valid
// until the addressed channel takes it. A transfer and a new accept can share
// one edge, so a steady stream moves with no bubbles.
module demux_rr_dispatcher #(
  parameter int DATA_W    = 8,
  parameter bit SKIP_BUSY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        ch_ready,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  output logic [1:0]        ptr,
  output logic [7:0]        xfer_count
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q;
  logic [1:0]        sel_q, ptr_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        vld_q;
  logic [7:0]        cnt_q;

  logic       xfer, acc;
  logic [1:0] start, pick, idx;

  // The held word leaves when its own channel is ready; a new word can be
  // taken when nothing is held or the held word leaves this same cycle.
  assign xfer     = (state_q == HOLD) & ch_ready[sel_q];
  assign in_ready = rst_n & ((state_q == IDLE) | ch_ready[sel_q]);
  assign acc      = in_valid & in_ready;

  // Search origin: after a same-cycle transfer, continue past the channel
  // just served rather than from the (not yet updated) pointer.
  assign start = xfer ? sel_q + 2'd1 : ptr_q;

  // Channel pick: lowest offset from start whose consumer is ready, falling
  // back to start itself when none is ready (or when skipping is disabled).
  always_comb begin
    pick = start;
    idx  = start;
    if (SKIP_BUSY) begin
      for (int i = 3; i >= 0; i--) begin
        idx = start + 2'(i);
        if (ch_ready[idx]) pick = idx;
      end
    end
  end

  // Dispatcher state: accept loads a new word, transfer advances the
  // round-robin pointer and the transfer counter; both may happen together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      data_q  <= '0;
      vld_q   <= 4'b0000;
      ptr_q   <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      if (xfer) begin
        ptr_q <= sel_q + 2'd1;
        cnt_q <= cnt_q + 8'd1;
      end
      if (acc) begin
        state_q <= HOLD;
        sel_q   <= pick;
        data_q  <= in_data;
        vld_q   <= 4'b0001 << pick;
      end else if (xfer) begin
        state_q <= IDLE;
        vld_q   <= 4'b0000;
      end
    end
  end

  assign sel        = sel_q;
  assign out_data   = data_q;
  assign out_valid  = vld_q;
  assign ptr        = ptr_q;
  assign xfer_count = cnt_q;

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher: one instance with strict ordering and one
// with busy-skipping share the same stimulus. A queue-free reference model
// tracks the held word per instance and is compared every cycle; directed
// literal checks pin the model on the key scenarios.
module tb_demux_rr_dispatcher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [3:0] ch_ready;

  logic       rdy [2];
  logic [1:0] sel [2];
  logic [7:0] od  [2];
  logic [3:0] ov  [2];
  logic [1:0] ptr [2];
  logic [7:0] cnt [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  demux_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(1'b0)) u_strict (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .ch_ready(ch_ready), .sel(sel[0]), .out_data(od[0]),
    .out_valid(ov[0]), .ptr(ptr[0]), .xfer_count(cnt[0]));

  demux_rr_dispatcher #(.DATA_W(8), .SKIP_BUSY(1'b1)) u_skip (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .ch_ready(ch_ready), .sel(sel[1]), .out_data(od[1]),
    .out_valid(ov[1]), .ptr(ptr[1]), .xfer_count(cnt[1]));

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: index 0 = strict order, index 1 = skip busy channels.
  bit         m_held [2];
  int         m_sel  [2];
  int         m_ptr  [2];
  int         m_cnt  [2];
  logic [7:0] m_data [2];

  always @(posedge clk or negedge rst_n) begin
    bit xf, ac, found;
    int st, c;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_held[k] <= 1'b0; m_sel[k] <= 0; m_ptr[k] <= 0;
        m_cnt[k] <= 0; m_data[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        xf = m_held[k] && ch_ready[m_sel[k]];
        ac = in_valid && (!m_held[k] || ch_ready[m_sel[k]]);
        st = xf ? (m_sel[k] + 1) % 4 : m_ptr[k];
        c = st;
        found = 1'b0;
        if (k == 1) begin
          for (int j = 0; j < 4; j++)
            if (!found && ch_ready[(st + j) % 4]) begin
              c = (st + j) % 4;
              found = 1'b1;
            end
        end
        if (xf) begin
          m_ptr[k] <= (m_sel[k] + 1) % 4;
          m_cnt[k] <= (m_cnt[k] + 1) % 256;
        end
        if (ac) begin
          m_held[k] <= 1'b1; m_sel[k] <= c; m_data[k] <= in_data;
        end else if (xf) begin
          m_held[k] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_out_valid[%0d]", k), ov[k], m_held[k] ? (1 << m_sel[k]) : 0);
        chk($sformatf("model_sel[%0d]", k), sel[k], m_sel[k]);
        chk($sformatf("model_out_data[%0d]", k), od[k], m_data[k]);
        chk($sformatf("model_ptr[%0d]", k), ptr[k], m_ptr[k]);
        chk($sformatf("model_xfer_count[%0d]", k), cnt[k], m_cnt[k]);
        chk($sformatf("model_in_ready[%0d]", k), rdy[k],
            int'(!m_held[k] || ch_ready[m_sel[k]]));
      end
    end
  end

  // Drive one cycle of inputs; returns just after the following falling edge,
  // by which point the outputs reflect the rising edge that used these inputs.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [3:0] cr);
    in_valid = v; in_data = d; ch_ready = cr;
    @(negedge clk); #1;
  endtask

  int exp_ov [6] = '{1, 2, 4, 8, 1, 2};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; ch_ready = 4'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", rdy[0], 0);
    chk("reset_out_valid", ov[1], 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Strict stream with every channel ready: back-to-back, no bubbles.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'h11 + 8'(i), 4'hF);
      chk("t2_out_valid", ov[0], exp_ov[i]);
      chk("t2_out_data", od[0], 8'h11 + i);
    end
    cyc(1'b0, 8'h00, 4'hF);
    chk("t2_xfer_count", cnt[0], 6);
    chk("t2_ptr", ptr[0], 2);
    chk("t2_idle", ov[0], 0);

    // Reset in the middle of a hold.
    cyc(1'b1, 8'h55, 4'h0);
    chk("t1_held", ov[1], 4'b0100);
    ch_ready = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("t1_out_valid", ov[k], 0);
      chk("t1_sel", sel[k], 0);
      chk("t1_ptr", ptr[k], 0);
      chk("t1_xfer_count", cnt[k], 0);
      chk("t1_in_ready", rdy[k], 0);
      chk("t1_out_data", od[k], 0);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Backpressure: word held stable, new source words ignored.
    cyc(1'b1, 8'hA5, 4'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 8'hEE, 4'h0);
      chk("t3_in_ready", rdy[0], 0);
      chk("t3_out_data", od[0], 8'hA5);
      chk("t3_out_valid", ov[0], 4'b0001);
    end
    cyc(1'b0, 8'h00, 4'b0001);
    chk("t3_ptr", ptr[0], 1);
    chk("t3_xfer_count", cnt[0], 1);
    chk("t3_idle", ov[0], 0);

    // Skip busy channels from ptr=1.
    cyc(1'b1, 8'h3C, 4'b1001);
    chk("t4_sel", sel[1], 3);
    chk("t4_out_valid", ov[1], 4'b1000);
    chk("t4_strict_sel", sel[0], 1);
    cyc(1'b0, 8'h00, 4'b1001);
    chk("t4_ptr", ptr[1], 0);
    chk("t4_strict_stuck", ov[0], 4'b0010);
    cyc(1'b0, 8'h00, 4'hF);

    // Simultaneous transfer and accept.
    cyc(1'b1, 8'h40, 4'b1100);
    chk("t6_pre_sel", sel[1], 2);
    cyc(1'b1, 8'h77, 4'b1100);
    chk("t6_sel", sel[1], 3);
    chk("t6_out_data", od[1], 8'h77);
    chk("t6_xfer_count", cnt[1], 3);
    cyc(1'b0, 8'h00, 4'hF);
    chk("t6_drain_count", cnt[1], 4);

    // 256 transfers wrap the counter back to where it started.
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 4'hF);
    cyc(1'b0, 8'h00, 4'hF);
    chk("t5_wrap_strict", cnt[0], 4);
    chk("t5_wrap_skip", cnt[1], 4);

    // Pseudo-random traffic against the model.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
